// File: rtl/buffer_reader.sv
// buffer_reader: snoops the producer's buffer write strobe, captures the buffered word one
// cycle later and streams it out LSB chunk first. Optional parity output: BUFFER_READER_PARITY_EN.
module buffer_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en_in,
    input  logic [DATA_WIDTH-1:0] buf_data_in,
    output logic                  stall_out,
    output logic                  rd_valid_out,
    input  logic                  rd_ready_in,
    output logic [OUT_WIDTH-1:0]  rd_data_out,
    output logic                  rd_last_out,
    input  logic                  clear_in,
    output logic                  overflow_out,
    output logic [CNT_WIDTH-1:0]  drop_cnt_out
`ifdef BUFFER_READER_PARITY_EN
    ,
    output logic                  rd_parity_out
`endif
);

    localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0]        BEAT_ONE  = BW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    if ((DATA_WIDTH % OUT_WIDTH) != 0 || BEATS < 1) begin : g_bad_width
        $error("buffer_reader: DATA_WIDTH must be a non-zero multiple of OUT_WIDTH");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [BW-1:0]           beat_q;
    logic                    valid_q;
    logic                    last_q;
    logic                    stall_q;
    logic                    overflow_q;
    logic [CNT_WIDTH-1:0]    drop_cnt_q;

    logic xfer;
    logic last_xfer;
    logic drop;

    assign xfer      = valid_q & rd_ready_in;
    assign last_xfer = xfer & last_q;

    // The buffer is released in the cycle its final chunk leaves, so the producer may
    // refill it then without counting as an overwrite.
    assign stall_out = stall_q & ~last_xfer;
    assign drop      = write_en_in & stall_out;

    assign rd_valid_out = valid_q;
    assign rd_last_out  = last_q;
    assign rd_data_out  = shift_q[OUT_WIDTH-1:0];
    assign overflow_out = overflow_q;
    assign drop_cnt_out = drop_cnt_q;

`ifdef BUFFER_READER_PARITY_EN
    assign rd_parity_out = valid_q & (^shift_q[OUT_WIDTH-1:0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            shift_q <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (write_en_in) begin
                        state_q <= LOAD;
                        stall_q <= 1'b1;
                    end
                end
                LOAD: begin
                    // Buffer output settled after the strobe; a write this cycle only
                    // lands in the buffer at this edge, so the old word is captured.
                    shift_q <= buf_data_in;
                    beat_q  <= '0;
                    valid_q <= 1'b1;
                    last_q  <= (LAST_BEAT == '0);
                    state_q <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        shift_q <= shift_q >> OUT_WIDTH;
                        beat_q  <= beat_q + BEAT_ONE;
                        last_q  <= ((beat_q + BEAT_ONE) == LAST_BEAT);
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (write_en_in) begin
                                state_q <= LOAD;
                            end else begin
                                state_q <= EMPTY;
                                stall_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // Overwrite tracking; a drop coinciding with clear leaves a fresh count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_in) begin
                drop_cnt_q <= CNT_ONE;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + CNT_ONE;
            end
        end else if (clear_in) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

endmodule
